// File: rtl/pool_pkg.sv
// pool_pkg: shared FSM states, beat indices and sizing helpers for the 2x2 window feeder
package pool_pkg;
  typedef enum logic [2:0] {S_EVEN, S_ODD_A, S_ODD_B, S_E1, S_E2, S_E3, S_E4} state_t;
  localparam logic [1:0] TL = 2'd0;
  localparam logic [1:0] TR = 2'd1;
  localparam logic [1:0] BL = 2'd2;
  localparam logic [1:0] BR = 2'd3;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int beat_off(input logic [1:0] b, input int w);
    return (b[1] ? w : 0) + (b[0] ? 1 : 0);
  endfunction
endpackage

// File: rtl/pool_line_buffer.sv
// pool_line_buffer: one feature-map row of pixels, one write port, two adjacent-column read ports
module pool_line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 8,
  parameter int COL_W      = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [COL_W-1:0]      wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [COL_W-1:0]      ra,
  output logic [DATA_WIDTH-1:0] rd0,
  output logic [DATA_WIDTH-1:0] rd1
);
  logic [DATA_WIDTH-1:0] mem [IMG_W];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  assign rd0 = mem[ra];
  assign rd1 = mem[ra + COL_W'(1)];
endmodule

// File: rtl/pool_window_feeder.sv
// pool_window_feeder: buffers the even row, then replays each 2x2 window as a TL,TR,BL,BR burst
module pool_window_feeder
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 10,
  parameter int IMG_W         = 8,
  parameter int IMG_H         = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [DATA_WIDTH-1:0]    in_data_i,
  input  logic                     in_last_i,
  output logic                     act_valid_o,
  output logic [DATA_WIDTH-1:0]    act_result_o,
  output logic [ADDRESS_WIDTH-1:0] act_result_address_o,
  output logic                     act_last_o,
  output logic                     frame_err_o
);
  localparam int COL_W = cnt_w(IMG_W);
  localparam int ROW_W = cnt_w(IMG_H);
  state_t st, ns;
  logic [COL_W-1:0] c, c0;
  logic [ROW_W-1:0] r;
  logic [DATA_WIDTH-1:0] hold_bl, hold_br, lb_tl, lb_tr, beat_d;
  logic [ADDRESS_WIDTH-1:0] top_addr;
  logic [1:0] beat;
  logic last_win, xfer, row_end, frame_end, win_end, emit;
  assign row_end    = c == COL_W'(IMG_W - 1);
  assign frame_end  = row_end && r == ROW_W'(IMG_H - 1);
  assign win_end    = c0 == COL_W'(IMG_W - 2);
  assign in_ready_o = st inside {S_EVEN, S_ODD_A, S_ODD_B} || (st == S_E4 && !win_end);
  assign xfer       = in_valid_i && in_ready_o;
  pool_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .IMG_W(IMG_W), .COL_W(COL_W)) u_lb (
    .clk(clk), .we(xfer && st == S_EVEN), .wa(c), .wd(in_data_i),
    .ra(c0), .rd0(lb_tl), .rd1(lb_tr)
  );
  always_comb begin
    ns = st;
    unique case (st)
      S_EVEN:  ns = (xfer && row_end) ? S_ODD_A : S_EVEN;
      S_ODD_A: ns = xfer ? S_ODD_B : S_ODD_A;
      S_ODD_B: ns = xfer ? S_E1 : S_ODD_B;
      S_E1:    ns = S_E2;
      S_E2:    ns = S_E3;
      S_E3:    ns = S_E4;
      S_E4:    ns = win_end ? S_EVEN : xfer ? S_ODD_B : S_ODD_A;
      default: ns = S_EVEN;
    endcase
  end
  assign emit   = ns inside {S_E1, S_E2, S_E3, S_E4};
  assign beat   = ns == S_E1 ? TL : ns == S_E2 ? TR : ns == S_E3 ? BL : BR;
  assign beat_d = ns == S_E1 ? lb_tl : ns == S_E2 ? lb_tr : ns == S_E3 ? hold_bl : hold_br;
  always_ff @(posedge clk) begin
    if (!rst) begin
      st                   <= S_EVEN;
      r                    <= '0;
      c                    <= '0;
      act_valid_o          <= 1'b0;
      act_result_o         <= '0;
      act_result_address_o <= '0;
      act_last_o           <= 1'b0;
      frame_err_o          <= 1'b0;
    end else begin
      st <= ns;
      if (xfer) begin
        c <= row_end ? '0 : c + 1'b1;
        r <= frame_end ? '0 : row_end ? r + 1'b1 : r;
        if (in_last_i != frame_end) frame_err_o <= 1'b1;
      end
      act_valid_o          <= emit;
      act_result_o         <= emit ? beat_d : '0;
      act_result_address_o <= emit ? top_addr + ADDRESS_WIDTH'(beat_off(beat, IMG_W)) : '0;
      act_last_o           <= ns == S_E4 && last_win;
    end
  end
  // window context is latched when the BL pixel (odd row, even column) arrives
  always_ff @(posedge clk) begin
    if (xfer && (st == S_ODD_A || st == S_E4)) begin
      hold_bl  <= in_data_i;
      c0       <= c;
      top_addr <= ADDRESS_WIDTH'(r - 1'b1) * ADDRESS_WIDTH'(IMG_W) + ADDRESS_WIDTH'(c);
      last_win <= r == ROW_W'(IMG_H - 1) && c == COL_W'(IMG_W - 2);
    end
    if (xfer && st == S_ODD_B) hold_br <= in_data_i;
  end
endmodule

// File: tb/tb_pool_window_feeder.sv
// tb_pool_window_feeder: randomized scoreboard bench for 4x4 and 2x2 feeder instances
module tb_pool_window_feeder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst4, v4, l4, rdy4, av4, al4, fe4;
  logic [7:0] d4i, ar4;
  logic [9:0] aa4;
  logic rst2, v2, l2, rdy2, av2, al2, fe2;
  logic [7:0] d2i, ar2;
  logic [9:0] aa2;
  typedef struct {logic [7:0] d; logic [9:0] a; logic l; int b;} exp_t;
  exp_t q4[$], q2[$];
  int vectors = 0, errs = 0;

  pool_window_feeder #(.DATA_WIDTH(8), .ADDRESS_WIDTH(10), .IMG_W(4), .IMG_H(4)) dut4 (
    .clk(clk), .rst(rst4), .in_valid_i(v4), .in_ready_o(rdy4), .in_data_i(d4i), .in_last_i(l4),
    .act_valid_o(av4), .act_result_o(ar4), .act_result_address_o(aa4), .act_last_o(al4),
    .frame_err_o(fe4));
  pool_window_feeder #(.DATA_WIDTH(8), .ADDRESS_WIDTH(10), .IMG_W(2), .IMG_H(2)) dut2 (
    .clk(clk), .rst(rst2), .in_valid_i(v2), .in_ready_o(rdy2), .in_data_i(d2i), .in_last_i(l2),
    .act_valid_o(av2), .act_result_o(ar2), .act_result_address_o(aa2), .act_last_o(al2),
    .frame_err_o(fe2));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // reference: every 2x2 window in raster order, beats TL,TR,BL,BR
  task automatic model(input int w, input int h, input int pix[16], input bit to2);
    exp_t e;
    for (int wr = 0; wr < h; wr += 2)
      for (int wc = 0; wc < w; wc += 2)
        for (int b = 0; b < 4; b++) begin
          e.d = 8'(pix[(wr + b / 2) * w + wc + b % 2]);
          e.a = 10'((wr + b / 2) * w + wc + b % 2);
          e.l = b == 3 && wr == h - 2 && wc == w - 2;
          e.b = b;
          if (to2) q2.push_back(e); else q4.push_back(e);
        end
  endtask

  function automatic int stall_exp(int k, bit fresh);
    int r = k / 4, c = k % 4;
    if (r % 2 == 1 && c % 2 == 0 && c > 0) return 3;
    if (r % 2 == 0 && c == 0 && !(k == 0 && fresh)) return 4;
    return 0;
  endfunction

  task automatic send(input bit s2, input logic [7:0] d, input bit l, output int waits);
    waits = 0;
    if (s2) begin v2 = 1'b1; d2i = d; l2 = l; end
    else begin v4 = 1'b1; d4i = d; l4 = l; end
    while (!(s2 ? rdy2 : rdy4) && waits < 20) begin
      waits++;
      @(posedge clk); #1;
    end
    if (!(s2 ? rdy2 : rdy4)) check("ready_timeout", 0, 1);
    @(posedge clk); #1;
    if (s2) v2 = 1'b0; else v4 = 1'b0;
  endtask

  task automatic drain(input bit s2);
    int n = 0;
    while ((s2 ? q2.size() : q4.size()) != 0 && n < 80) begin
      @(posedge clk); #1;
      n++;
    end
    check(s2 ? "drain2_left" : "drain4_left", s2 ? q2.size() : q4.size(), 0);
  endtask

  // mode 0: continuous valid, 1: valid toggles, 2: random gaps; base<0 gives random pixels
  task automatic frame4(input int base, input int err_k, input int mode, input bit fresh);
    int pix[16];
    int w;
    for (int k = 0; k < 16; k++) pix[k] = base < 0 ? int'($urandom_range(0, 255)) : (base + k) & 255;
    model(4, 4, pix, 0);
    for (int k = 0; k < 16; k++) begin
      if (mode == 2) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send(0, 8'(pix[k]), k == 15 || k == err_k, w);
      if (mode == 0) check($sformatf("stall_px%0d", k), w, stall_exp(k, fresh));
      if (mode == 1) begin @(posedge clk); #1; end
      if (err_k >= 0 && k == err_k - 1) check("err_before", fe4, 0);
      if (err_k >= 0 && k == err_k) check("err_rise", fe4, 1);
    end
  endtask

  task automatic run4();
    int pix[16];
    int w;
    bit found = 0;
    rst4 = 1'b0; v4 = 1'b0; d4i = '0; l4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", av4, 0);
    check("rst_ready", rdy4, 1);
    check("rst_err", fe4, 0);
    check("rst_data", ar4, 0);
    rst4 = 1'b1;
    frame4(0, -1, 0, 1);
    frame4(100, -1, 0, 0);
    drain(0);
    frame4(0, -1, 1, 1);
    drain(0);
    check("err_clean", fe4, 0);
    frame4(0, 9, 0, 1);
    drain(0);
    check("err_sticky", fe4, 1);
    for (int k = 0; k < 16; k++) pix[k] = k;
    model(4, 4, pix, 0);
    for (int k = 0; k < 8; k++) send(0, 8'(k), 1'b0, w);
    for (int n = 0; n < 10 && !found; n++)
      if (av4 && ar4 == 8'd3 && aa4 == 10'd3) found = 1;
      else begin @(posedge clk); #1; end
    check("tr_seen", found, 1);
    rst4 = 1'b0;
    @(posedge clk); #1;
    check("abort_valid", av4, 0);
    check("abort_ready", rdy4, 1);
    check("abort_err", fe4, 0);
    q4.delete();
    rst4 = 1'b1;
    frame4(0, -1, 0, 1);
    drain(0);
    repeat (6) frame4(-1, -1, 2, 0);
    drain(0);
    check("err_random", fe4, 0);
  endtask

  task automatic run2();
    int pix[16];
    int w;
    rst2 = 1'b0; v2 = 1'b0; d2i = '0; l2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst2_valid", av2, 0);
    check("rst2_ready", rdy2, 1);
    rst2 = 1'b1;
    for (int f = 0; f < 5; f++) begin
      pix = '{default: 0};
      for (int k = 0; k < 4; k++) pix[k] = f == 0 ? (k == 0 ? 7 : k == 1 ? 3 : k == 2 ? 9 : 1)
                                                  : int'($urandom_range(0, 255));
      model(2, 2, pix, 1);
      for (int k = 0; k < 4; k++) begin
        send(1, 8'(pix[k]), k == 3, w);
        check($sformatf("stall2_f%0d_px%0d", f, k), w, (f > 0 && k == 0) ? 4 : 0);
      end
    end
    drain(1);
    check("err2_clean", fe2, 0);
  endtask

  initial begin : mon4
    exp_t e;
    bit pv = 0, rp = 0;
    int lb = 3;
    forever begin
      @(negedge clk);
      if (av4 === 1'b1) begin
        if (q4.size() == 0) check("beat4_unexpected", ar4, 32'hFFFF);
        else begin
          e = q4.pop_front();
          vectors++;
          if (ar4 !== e.d || aa4 !== e.a || al4 !== e.l) begin
            errs++;
            $display("FAIL beat4: got d=%0d a=%0d l=%0b expected d=%0d a=%0d l=%0b",
                     ar4, aa4, al4, e.d, e.a, e.l);
          end
          if (e.b != 0) check("beat4_gap", pv, 1);
          lb = e.b;
        end
      end else begin
        check("idle4_zero", {ar4, aa4, al4}, 0);
        if (pv && rp) check("burst4_truncated", lb, 3);
      end
      pv = av4 === 1'b1;
      rp = rst4;
    end
  end

  initial begin : mon2
    exp_t e;
    forever begin
      @(negedge clk);
      if (av2 === 1'b1) begin
        if (q2.size() == 0) check("beat2_unexpected", ar2, 32'hFFFF);
        else begin
          e = q2.pop_front();
          vectors++;
          if (ar2 !== e.d || aa2 !== e.a || al2 !== e.l) begin
            errs++;
            $display("FAIL beat2: got d=%0d a=%0d l=%0b expected d=%0d a=%0d l=%0b",
                     ar2, aa2, al2, e.d, e.a, e.l);
          end
        end
      end else check("idle2_zero", {ar2, aa2, al2}, 0);
    end
  end

  initial begin
    fork
      run4();
      run2();
    join
    repeat (8) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
